nn_result_reader: RTL

Host-side initiator for the neural accelerator's `run_inference`/`ready` handshake, sitting between the ARM register interface and the control unit. On a CPU start request it launches one inference, waits for completion, then walks `result_selector` across every output node and captures each result into a local buffer. While capturing, it computes the arg-max classification and exposes both the buffer and the classification to software. A timeout guards against a control unit that never answers.

---
 rtl/nn_result_reader_if.sv | 28 ++
 rtl/nn_result_reader.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/nn_result_reader_if.sv
// nn_result_reader_if: CPU register-block and control-unit signals seen by the result reader.
// master is the reader itself; slave is the surrounding CPU/control-unit side.
interface nn_result_reader_if #(
    parameter int DW = 16
);
    logic                 start;
    logic                 ready;
    logic                 run_inference;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [7:0]           outputNodeNumber;
    logic [7:0]           result_selector;
    logic [7:0]           argmax;
    logic [7:0]           node_count;
    logic [7:0]           rd_idx;
    logic signed [DW-1:0] result;
    logic signed [DW-1:0] max_value;
    logic signed [DW-1:0] rd_data;
    modport master (
        input  start, ready, outputNodeNumber, result, rd_idx,
        output run_inference, result_selector, busy, done, error, argmax, max_value, node_count, rd_data
    );
    modport slave (
        output start, ready, outputNodeNumber, result, rd_idx,
        input  run_inference, result_selector, busy, done, error, argmax, max_value, node_count, rd_data
    );
endinterface

// File: rtl/nn_result_reader.sv
// nn_result_reader: launches one inference, waits for completion, then reads every output
// node into a local buffer while tracking the arg-max classification.
module nn_result_reader #(
    parameter int DW        = 16,
    parameter int MAX_NODES = 16,
    parameter int SEL_LAT   = 1,
    parameter int TIMEOUT   = 65535
) (
    input logic                clk,
    input logic                reset,
    nn_result_reader_if.master bus
);
    localparam int IW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, READ, DONE} state_t;
    state_t               state_q, state_d;
    logic                 pending_q, pending_d;
    logic                 error_q, error_d;
    logic                 run_q, done_q, busy_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           lat_q, lat_d;
    logic [7:0]           idx_q, idx_d;
    logic [7:0]           count_q, count_d;
    logic [7:0]           argmax_q, argmax_d;
    logic signed [DW-1:0] max_q, max_d;
    logic signed [DW-1:0] rd_q, rd_d;
    logic signed [DW-1:0] mem_q [MAX_NODES];
    logic signed [DW-1:0] mem_d [MAX_NODES];
    logic                 expired, capture;
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        error_d   = error_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        idx_d     = idx_q;
        count_d   = count_q;
        argmax_d  = argmax_q;
        max_d     = max_q;
        mem_d     = mem_q;
        expired   = cnt_q == CW'(TIMEOUT - 1);
        capture   = state_q == READ && lat_q == 2'(SEL_LAT);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pending_d = 1'b1;
                    error_d   = 1'b0;
                end
                if (pending_q && bus.ready) begin
                    pending_d = 1'b0;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (!bus.ready) begin
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else if (expired) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.ready) begin
                    count_d  = (32'(bus.outputNodeNumber) > MAX_NODES) ? 8'(MAX_NODES) : bus.outputNodeNumber;
                    idx_d    = '0;
                    lat_d    = '0;
                    argmax_d = '0;
                    max_d    = {1'b1, {(DW-1){1'b0}}};
                    state_d  = (count_d == 8'd0) ? DONE : READ;
                end else if (expired) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            READ: begin
                lat_d = lat_q + 1'b1;
                if (capture) begin
                    lat_d                 = '0;
                    mem_d[idx_q[IW-1:0]]  = bus.result;
                    // strict compare keeps the lowest index on ties
                    if ($signed(bus.result) > max_q) begin
                        max_d    = bus.result;
                        argmax_d = idx_q;
                    end
                    if (idx_q == count_q - 8'd1) state_d = DONE;
                    else idx_d = idx_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        rd_d = (32'(bus.rd_idx) < MAX_NODES) ? mem_q[bus.rd_idx[IW-1:0]] : '0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            error_q   <= 1'b0;
            run_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            lat_q     <= '0;
            idx_q     <= '0;
            count_q   <= '0;
            argmax_q  <= '0;
            max_q     <= '0;
            rd_q      <= '0;
            for (int i = 0; i < MAX_NODES; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            error_q   <= error_d;
            run_q     <= state_d == LAUNCH;
            done_q    <= state_d == DONE;
            busy_q    <= state_d != IDLE;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            argmax_q  <= argmax_d;
            max_q     <= max_d;
            rd_q      <= rd_d;
            mem_q     <= mem_d;
        end
    end
    assign bus.run_inference   = run_q;
    assign bus.result_selector = idx_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.error           = error_q;
    assign bus.argmax          = argmax_q;
    assign bus.max_value       = max_q;
    assign bus.node_count      = count_q;
    assign bus.rd_data         = rd_q;
endmodule
